// File: rtl/alu.sv
// Registered WIDTH-bit ALU: add, subtract, bitwise logic and single-bit shifts.
// Operands are sampled when in_valid is high. The result and the carry, zero and
// overflow flags are registered one cycle later. When in_valid is low, only
// out_valid drops; the result and flags hold their last values.
module alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpNot = 3'b101,
        OpShl = 3'b110,
        OpShr = 3'b111
    } op_e;

    logic [WIDTH-1:0] res_d, res_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_q;
    logic             valid_q;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // Extended-width add and subtract. The top bit of each is carry-out or borrow.
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    // Decode the opcode into the next result and the next flag values.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op_e'(OP))
            OpAdd: begin
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
                // Overflow: both operands share a sign and the result's sign differs from it.
                ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OpSub: begin
                res_d   = diff_ext[WIDTH-1:0];
                carry_d = diff_ext[WIDTH];
                // Overflow: operand signs differ and the result's sign differs from A's.
                ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OpAnd: res_d = A & B;
            OpOr:  res_d = A | B;
            OpXor: res_d = A ^ B;
            OpNot: res_d = ~A;
            OpShl: begin
                res_d   = {A[WIDTH-2:0], 1'b0};
                carry_d = A[WIDTH-1];
            end
            OpShr: begin
                res_d   = {1'b0, A[WIDTH-1:1]};
                carry_d = A[0];
            end
            default: begin
                res_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Output registers. out_valid follows in_valid; the result and flags load only on valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q   <= res_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                zero_q  <= (res_d == '0);
            end
        end
    end

    assign alu_out   = res_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu. It applies a table of directed vectors, then reset
// and hold sequences, then random traffic checked against an arithmetic model.
module tb_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A, B;
    logic [2:0]   OP;
    logic [W-1:0] alu_out;
    logic         out_valid, carry, zero, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .alu_out   (alu_out),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] r, input logic v_out,
                             input logic c, input logic z, input logic v);
        check({name, ".alu_out"}, int'(alu_out), int'(r));
        check({name, ".out_valid"}, int'(out_valid), int'(v_out));
        check({name, ".carry"}, int'(carry), int'(c));
        check({name, ".zero"}, int'(zero), int'(z));
        check({name, ".overflow"}, int'(overflow), int'(v));
    endtask

    // Reference model built from the operation definitions, using plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic c, output logic v);
        int m  = 2 ** W;
        int ua = int'(a);
        int ub = int'(b);
        int sa = (ua >= m / 2) ? ua - m : ua;
        int sb = (ub >= m / 2) ? ub - m : ub;
        int t;
        int res;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                res = (ua + ub) % m;
                c = (ua + ub) >= m;
                t = sa + sb;
                v = (t > m / 2 - 1) || (t < -(m / 2));
            end
            3'd1: begin
                res = (ua - ub + m) % m;
                c = ua < ub;
                t = sa - sb;
                v = (t > m / 2 - 1) || (t < -(m / 2));
            end
            3'd2: res = int'(a & b);
            3'd3: res = int'(a | b);
            3'd4: res = int'(a ^ b);
            3'd5: res = m - 1 - ua;
            3'd6: begin
                res = (ua * 2) % m;
                c = ua >= m / 2;
            end
            default: begin
                res = ua / 2;
                c = (ua % 2) == 1;
            end
        endcase
        r = res[W-1:0];
    endfunction

    initial begin
        logic [W-1:0] er;
        logic ec, ez, ev, eval;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        logic rv;

        //          op      a        b        r        c     z     v
        vecs[0]  = {3'b000, 4'b0011, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = {3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = {3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = {3'b001, 4'b0010, 4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[4]  = {3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1};
        vecs[5]  = {3'b010, 4'b0101, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0};
        vecs[6]  = {3'b011, 4'b1110, 4'b1001, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[7]  = {3'b100, 4'b1111, 4'b1100, 4'b0011, 1'b0, 1'b0, 1'b0};
        vecs[8]  = {3'b101, 4'b1000, 4'b1011, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[9]  = {3'b110, 4'b1100, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[10] = {3'b111, 4'b0011, 4'b1101, 4'b0001, 1'b1, 1'b0, 1'b0};
        vecs[11] = {3'b111, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};

        // Power-up reset state
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = '0;
        #1;
        check_all("por", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back-to-back with in_valid held high
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1; OP = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].r, 1'b1, vecs[i].c, vecs[i].z, vecs[i].v);
        end

        // Hold: a valid ADD, then three idle cycles with scrambled inputs
        @(negedge clk);
        in_valid = 1'b1; OP = 3'b000; A = 4'b0011; B = 4'b0001;
        @(posedge clk); #1;
        check_all("hold_add", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0; OP = 3'($urandom); A = 4'b1111; B = 4'($urandom);
            @(posedge clk); #1;
            check_all($sformatf("hold%0d", k), 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Mid-stream asynchronous reset with valid traffic in flight
        @(negedge clk);
        in_valid = 1'b1; OP = 3'b000; A = 4'b0111; B = 4'b0001;
        @(posedge clk); #1;
        check_all("pre_rst", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model; the expected values hold when in_valid is low
        er = '0; ec = 0; ez = 0; ev = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rop = 3'($urandom); ra = 4'($urandom); rb = 4'($urandom);
            rv  = ($urandom_range(3, 0) != 0);
            in_valid = rv; OP = rop; A = ra; B = rb;
            eval = rv;
            if (rv) begin
                model(rop, ra, rb, er, ec, ev);
                ez = (er == '0);
            end
            @(posedge clk); #1;
            check_all($sformatf("rnd%0d_op%0d", n, rop), er, eval, ec, ez, ev);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
